// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the core's single-port word memory.
// Load/store has priority; a starvation counter forces fetch through.
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [3:0]        ls_wmask,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_LS_RD,
    OWN_LS_WR
  } owner_e;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  owner_e            owner_q, owner_d;
  logic [3:0]        starve_q, starve_d;
  logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;
  logic              starved;

  assign starved = (starve_q == SMAX);

  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (RESETN) begin
      unique case (1'b1)
        if_req && (!ls_req || starved): if_gnt = 1'b1;
        ls_req && !(if_req && starved): ls_gnt = 1'b1;
        default: ;
      endcase
    end
  end

  assign mem_en    = if_gnt | ls_gnt;
  assign mem_addr  = if_gnt ? if_addr : ls_addr;
  assign mem_we    = (ls_gnt && ls_we) ? ls_wmask : 4'b0000;
  assign mem_wdata = ls_wdata;

  always_comb begin
    owner_d = OWN_NONE;
    unique case (1'b1)
      if_gnt:           owner_d = OWN_IF;
      ls_gnt && ls_we:  owner_d = OWN_LS_WR;
      ls_gnt && !ls_we: owner_d = OWN_LS_RD;
      default: ;
    endcase
  end

  // counts only cycles where a pending fetch lost to load/store
  always_comb begin
    starve_d = starve_q;
    if (!if_req || if_gnt)
      starve_d = 4'd0;
    else if (ls_gnt && !starved)
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      owner_q    <= OWN_NONE;
      starve_q   <= 4'd0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
      if (owner_q == OWN_IF)
        if_rdata_q <= mem_rdata;
      if (owner_q == OWN_LS_RD)
        ls_rdata_q <= mem_rdata;
      else if (owner_q == OWN_LS_WR)
        ls_rdata_q <= '0;
    end
  end

  // response data comes straight from memory in the response cycle, then holds
  assign if_rvalid = (owner_q == OWN_IF);
  assign ls_rvalid = (owner_q == OWN_LS_RD) || (owner_q == OWN_LS_WR);
  assign busy      = (owner_q != OWN_NONE);

  always_comb begin
    if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
    ls_rdata = ls_rdata_q;
    if (owner_q == OWN_LS_RD)
      ls_rdata = mem_rdata;
    else if (owner_q == OWN_LS_WR)
      ls_rdata = '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural
// synchronous byte-masked memory behind the arbiter.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        if_req = 1'b0;
  logic [7:0]  if_addr = 8'h00;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [7:0]  ls_addr = 8'h00;
  logic [31:0] ls_wdata = 32'h0;
  logic [3:0]  ls_wmask = 4'h0;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;

  logic        bd_en = 1'b0;
  logic [7:0]  bd_addr = 8'h00;
  logic [31:0] bd_data = 32'h0;
  logic [31:0] mem [256];

  int n_chk = 0;
  int n_pass = 0;

  mem_port_arbiter #(
    .ADDR_W(8), .DATA_W(32), .STARVE_MAX(3)
  ) dut (
    .CLK(CLK), .RESETN(RESETN),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_wmask(ls_wmask), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (bd_en) begin
      mem[bd_addr] <= bd_data;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h exp %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0;
    ls_req = 1'b0;
    ls_we = 1'b0;
    ls_wmask = 4'h0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    bd_en = 1'b1;
    bd_addr = a;
    bd_data = d;
    tick();
    bd_en = 1'b0;
  endtask

  initial begin
    logic ei;
    // reset: requests must not be granted while RESETN is low
    if_req = 1'b1;
    if_addr = 8'h05;
    #1;
    check("rst_if_gnt", 32'(if_gnt), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check("rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_ls_rdata", ls_rdata, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    if_req = 1'b0;
    preload(8'h01, 32'h0000_1111);
    preload(8'h02, 32'h2222_0002);
    preload(8'h03, 32'h3333_0003);
    preload(8'h05, 32'h0010_0093);
    preload(8'h10, 32'h1122_3344);
    preload(8'h20, 32'hA0A0_0020);
    preload(8'h21, 32'hB1B1_0021);
    preload(8'h30, 32'h0000_0000);
    RESETN = 1'b1;
    tick();

    // first fetch after power-up
    if_req = 1'b1;
    if_addr = 8'h05;
    @(negedge CLK);
    check("f1_if_gnt", 32'(if_gnt), 32'd1);
    check("f1_ls_gnt", 32'(ls_gnt), 32'd0);
    check("f1_mem_addr", 32'(mem_addr), 32'h05);
    check("f1_mem_we", 32'(mem_we), 32'h0);
    check("f1_busy_issue", 32'(busy), 32'd0);
    tick();
    idle();
    check("f1_if_rvalid", 32'(if_rvalid), 32'd1);
    check("f1_if_rdata", if_rdata, 32'h0010_0093);
    check("f1_busy_resp", 32'(busy), 32'd1);
    tick();
    check("f1_rvalid_pulse", 32'(if_rvalid), 32'd0);
    check("f1_busy_after", 32'(busy), 32'd0);
    check("f1_rdata_hold", if_rdata, 32'h0010_0093);

    // partial store, then load back the merged word
    ls_req = 1'b1;
    ls_we = 1'b1;
    ls_addr = 8'h10;
    ls_wdata = 32'hDEAD_BEEF;
    ls_wmask = 4'b0011;
    @(negedge CLK);
    check("st_ls_gnt", 32'(ls_gnt), 32'd1);
    check("st_mem_we", 32'(mem_we), 32'h3);
    check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("st_mem_addr", 32'(mem_addr), 32'h10);
    tick();
    ls_we = 1'b0;
    check("st_ls_rvalid", 32'(ls_rvalid), 32'd1);
    check("st_ls_rdata", ls_rdata, 32'h0);
    @(negedge CLK);
    check("ld_mem_we", 32'(mem_we), 32'h0);
    tick();
    idle();
    check("ld_ls_rvalid", 32'(ls_rvalid), 32'd1);
    check("ld_ls_rdata", ls_rdata, 32'h1122_BEEF);

    // zero-mask store is acked but leaves memory intact
    ls_req = 1'b1;
    ls_we = 1'b1;
    ls_wdata = 32'h5555_5555;
    ls_wmask = 4'b0000;
    @(negedge CLK);
    check("z_ls_gnt", 32'(ls_gnt), 32'd1);
    tick();
    ls_we = 1'b0;
    check("z_ls_rvalid", 32'(ls_rvalid), 32'd1);
    check("z_ls_rdata", ls_rdata, 32'h0);
    tick();
    idle();
    check("z_ld_rdata", ls_rdata, 32'h1122_BEEF);
    tick();
    check("z_ls_rdata_hold", ls_rdata, 32'h1122_BEEF);

    // both requesters held: LS,LS,LS,IF repeating
    if_req = 1'b1;
    if_addr = 8'h20;
    ls_req = 1'b1;
    ls_we = 1'b0;
    ls_addr = 8'h21;
    for (int k = 0; k < 8; k++) begin
      ei = (k % 4 == 3);
      @(negedge CLK);
      check($sformatf("sv_if_gnt%0d", k), 32'(if_gnt), 32'(ei));
      check($sformatf("sv_ls_gnt%0d", k), 32'(ls_gnt), 32'(!ei));
      tick();
      check($sformatf("sv_if_rv%0d", k), 32'(if_rvalid), 32'(ei));
      check($sformatf("sv_ls_rv%0d", k), 32'(ls_rvalid), 32'(!ei));
      if (ei) check($sformatf("sv_if_rd%0d", k), if_rdata, 32'hA0A0_0020);
      else check($sformatf("sv_ls_rd%0d", k), ls_rdata, 32'hB1B1_0021);
    end
    idle();
    tick();

    // back-to-back load, load, fetch
    ls_req = 1'b1;
    ls_addr = 8'h01;
    tick();
    ls_addr = 8'h02;
    check("bb_ls_rv1", 32'(ls_rvalid), 32'd1);
    check("bb_ls_rd1", ls_rdata, 32'h0000_1111);
    tick();
    ls_req = 1'b0;
    if_req = 1'b1;
    if_addr = 8'h03;
    check("bb_ls_rv2", 32'(ls_rvalid), 32'd1);
    check("bb_ls_rd2", ls_rdata, 32'h2222_0002);
    tick();
    idle();
    check("bb_if_rv3", 32'(if_rvalid), 32'd1);
    check("bb_ls_rv3", 32'(ls_rvalid), 32'd0);
    check("bb_if_rd3", if_rdata, 32'h3333_0003);
    tick();

    // store then fetch of the same word on the next cycle
    ls_req = 1'b1;
    ls_we = 1'b1;
    ls_addr = 8'h30;
    ls_wdata = 32'hCAFE_F00D;
    ls_wmask = 4'hF;
    tick();
    idle();
    if_req = 1'b1;
    if_addr = 8'h30;
    check("hz_ls_rv", 32'(ls_rvalid), 32'd1);
    tick();
    idle();
    check("hz_if_rv", 32'(if_rvalid), 32'd1);
    check("hz_if_rd", if_rdata, 32'hCAFE_F00D);
    tick();

    // reset mid-access with starve count built up
    if_req = 1'b1;
    if_addr = 8'h20;
    ls_req = 1'b1;
    ls_we = 1'b0;
    ls_addr = 8'h01;
    tick();
    tick();
    RESETN = 1'b0;
    #1;
    check("mr_ls_rvalid", 32'(ls_rvalid), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_if_rdata", if_rdata, 32'h0);
    check("mr_ls_rdata", ls_rdata, 32'h0);
    check("mr_ls_gnt", 32'(ls_gnt), 32'd0);
    check("mr_if_gnt", 32'(if_gnt), 32'd0);
    tick();
    idle();
    RESETN = 1'b1;
    tick();
    check("mr_post_ls_rv", 32'(ls_rvalid), 32'd0);
    check("mr_post_if_rv", 32'(if_rvalid), 32'd0);
    if_req = 1'b1;
    ls_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check($sformatf("mr_if_gnt%0d", k), 32'(if_gnt), 32'(k == 3));
      tick();
    end
    idle();
    tick();
    if_req = 1'b1;
    if_addr = 8'h05;
    @(negedge CLK);
    check("mr_f_gnt", 32'(if_gnt), 32'd1);
    tick();
    idle();
    check("mr_f_rv", 32'(if_rvalid), 32'd1);
    check("mr_f_rd", if_rdata, 32'h0010_0093);
    tick();

    // fetch idle during a load stream: counter starts from zero
    ls_req = 1'b1;
    ls_addr = 8'h21;
    for (int k = 0; k < 10; k++) tick();
    check("ls_stream_rv", 32'(ls_rvalid), 32'd1);
    if_req = 1'b1;
    if_addr = 8'h20;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check($sformatf("ls_if_gnt%0d", k), 32'(if_gnt), 32'(k == 3));
      tick();
    end
    idle();
    check("ls_if_rd", if_rdata, 32'hA0A0_0020);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single-port 256 x 32 word memory between two requesters.
- The instruction-fetch path (FETCH_INSTR state) and the load/store path (is_load / is_store execute) each get their own port.
- Issues at most one memory access per cycle and returns read data or write acknowledgement one cycle later.
- Fixed priority to load/store, with a starvation guard so fetch always progresses.

Parameters:
- ADDR_W, 8, word-address width; memory depth 2**ADDR_W.
- DATA_W, 32, data word width; must be 32 (byte mask is 4 bits).
- STARVE_MAX, 3, consecutive denied cycles of a pending fetch before fetch is forced to win; range 1..15.

Ports:
- CLK  in  1  system clock, all state on rising edge
- RESETN  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  fetch data valid (registered, one cycle after if_gnt)
- if_rdata  out  DATA_W  fetch data, valid when if_rvalid
- ls_req  in  1  load/store request; held with ls_we/ls_addr/ls_wdata/ls_wmask until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  load/store word address
- ls_wdata  in  DATA_W  store data
- ls_wmask  in  4  store byte enables, bit i = byte i
- ls_gnt  out  1  load/store accepted this cycle (combinational)
- ls_rvalid  out  1  load data valid, or store complete (registered)
- ls_rdata  out  DATA_W  load data; 0 for store acks
- mem_en  out  1  memory access this cycle
- mem_we  out  4  byte write enables
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; synchronous, valid the cycle after mem_en
- busy  out  1  a response is outstanding (resp_owner != NONE)

Behaviour:
- **Reset (RESETN low, async):**
  - resp_owner = NONE, starve_cnt = 0.
  - if_rvalid = ls_rvalid = 0; if_rdata = ls_rdata = 0; busy = 0.
  - Grant outputs are 0 while RESETN is low.
  - Reset mid-access discards the pending response; no rvalid is issued after deassertion.
- **Arbitration (combinational, every cycle):**
  - Only ls_req: ls wins.
  - Only if_req: if wins.
  - Both, starve_cnt < STARVE_MAX: ls wins.
  - Both, starve_cnt == STARVE_MAX: if wins.
  - Neither: no grant, mem_en = 0.
- **Memory drive on grant:**
  - mem_en = 1; mem_addr = winner address.
  - mem_we = ls_wmask if ls wins with ls_we = 1; otherwise 4'b0000.
  - mem_wdata = ls_wdata (don't-care otherwise).
  - Exactly one of if_gnt / ls_gnt is asserted, never both.
- **starve_cnt:**
  - +1 (saturating at STARVE_MAX) when if_req and ls wins.
  - Cleared when if wins or if_req = 0.
- **Response state machine, resp_owner in {NONE, IF, LS_RD, LS_WR}:**
  - Next state is set by the grant this cycle: if grant → IF; ls load → LS_RD; ls store → LS_WR; no grant → NONE.
  - Back-to-back grants every cycle are allowed; the response of access N overlaps issue of access N+1.
  - **IF:** if_rvalid = 1, if_rdata = mem_rdata.
  - **LS_RD:** ls_rvalid = 1, ls_rdata = mem_rdata.
  - **LS_WR:** ls_rvalid = 1, ls_rdata = 0.
  - rvalid is a single-cycle pulse per grant. rdata holds its last value when rvalid = 0.
- **Latency:**
  - Grant is same-cycle as request when uncontended.
  - Response is exactly 1 cycle after grant.
- **Store edge case:** store with ls_wmask = 0 is still granted and acked; memory is unchanged.
- **Hazards:**
  - Fetch and store to the same address in consecutive cycles: the fetch returns the new data, because the store is issued first and memory is write-before-read across cycles.
  - Same-cycle conflict cannot occur (single grant).
- **Address range:** addresses span the full depth; no wrap or bounds logic.

Test Plan:
- Reset, then if_req=1, if_addr=0x05, mem[5]=0x00100093 → if_gnt same cycle; next cycle if_rvalid=1, if_rdata=0x00100093; busy=1 during response cycle only.
- ls store addr 0x10, wdata=0xDEADBEEF, wmask=4'b0011, prior mem=0x11223344 → mem_we=0011; ls_rvalid next cycle, ls_rdata=0; subsequent load of 0x10 returns 0x1122BEEF.
- if_req and ls_req held high continuously, STARVE_MAX=3 → grant sequence LS,LS,LS,IF,LS,LS,LS,IF; never both grants; rvalid pulses match owners one cycle later.
- Back-to-back: load 0x01, load 0x02, fetch 0x03 on consecutive cycles → three consecutive rvalid pulses with data mem[1], mem[2], mem[3] on correct ports.
- Assert RESETN low in the cycle after a load grant → no ls_rvalid after release, outputs 0, starve_cnt 0; next fetch behaves as after power-up.
- if_req=0 while ls_req streams 10 cycles, then if_req=1 with ls_req still high → fetch granted on the 4th cycle after if_req rises (counter started at 0, not saturated).
